db9_pad_scanner: RTL and testbench

DB9_PAD_SCANNER -- requirements
Module: db9_pad_scanner

---
 rtl/db9_pad_scanner.sv | 182 ++++++++++++++++++
 tb/tb_db9_pad_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/db9_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : db9_pad_scanner
// Description : Scans a DB9 port for Atari, Megadrive 3-button and 6-button
//               pads and publishes one coherent result per scan frame.
// Revision    : 1.0 - initial release
// ============================================================================
module db9_pad_scanner #(
  parameter int STEP_CYCLES = 280,
  parameter int IDLE_STEPS  = 170
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] db9_in,
  output logic       db9_sel,
  output logic [5:0] joy_out,
  output logic [5:0] ext_out,
  output logic [1:0] pad_type,
  output logic       frame_done
);

  localparam int c_cnt_w  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int c_idle_w = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;

  localparam logic [3:0] c_st_p0   = 4'd0;
  localparam logic [3:0] c_st_p1   = 4'd1;
  localparam logic [3:0] c_st_p2   = 4'd2;
  localparam logic [3:0] c_st_p3   = 4'd3;
  localparam logic [3:0] c_st_p4   = 4'd4;
  localparam logic [3:0] c_st_p5   = 4'd5;
  localparam logic [3:0] c_st_p6   = 4'd6;
  localparam logic [3:0] c_st_p7   = 4'd7;
  localparam logic [3:0] c_st_idle = 4'd8;

  localparam logic [c_cnt_w-1:0]  c_step_last = c_cnt_w'(STEP_CYCLES - 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_STEPS - 1);

  logic [5:0]          r_sync1, r_sync2;
  logic [3:0]          r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [c_idle_w-1:0] r_idle, w_idle_nxt;
  logic                w_step_end;
  logic                w_sel_nxt;
  logic                w_update;

  // Only the bits each phase contributes are kept.
  logic [5:0] r_p0;
  logic [1:0] r_p1_sa;
  logic [1:0] r_p1_lr;
  logic [3:0] r_p5_dir;
  logic [3:0] r_p6_ext;

  logic       r_sel;
  logic [5:0] r_joy, r_ext;
  logic [1:0] r_type;
  logic       r_done;

  logic       w_is_md, w_is_six;
  logic [5:0] w_ext_nxt;
  logic [1:0] w_type_nxt;

  assign w_step_end = (r_cnt == c_step_last);

  // ---- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  // ---- next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idle_nxt  = r_idle;
    if (!enable) begin
      w_state_nxt = c_st_idle;
      w_cnt_nxt   = '0;
      w_idle_nxt  = '0;
    end else if (w_step_end) begin
      w_cnt_nxt = '0;
      case (r_state)
        c_st_idle: begin
          if (r_idle == c_idle_last) begin
            w_state_nxt = c_st_p0;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt = r_idle + 1'b1;
          end
        end
        c_st_p0, c_st_p1, c_st_p2, c_st_p3,
        c_st_p4, c_st_p5, c_st_p6: w_state_nxt = r_state + 4'd1;
        default: begin
          w_state_nxt = c_st_idle;
          w_idle_nxt  = '0;
        end
      endcase
    end
  end

  // ---- output decode (select is registered from the next state)
  always_comb begin
    w_sel_nxt = 1'b1;
    case (w_state_nxt)
      c_st_p1, c_st_p3, c_st_p5, c_st_p7: w_sel_nxt = 1'b0;
      default:                            w_sel_nxt = 1'b1;
    endcase
    w_update = enable && w_step_end && (r_state == c_st_p7);
  end

  assign w_is_md    = (r_p1_lr == 2'b00);
  assign w_is_six   = w_is_md && (r_p5_dir == 4'b0000);
  assign w_ext_nxt  = w_is_six ? {r_p6_ext[0], r_p6_ext[3], r_p6_ext[2], r_p6_ext[1], r_p1_sa} :
                      w_is_md  ? {4'hF, r_p1_sa} : 6'h3F;
  assign w_type_nxt = w_is_six ? 2'b10 : (w_is_md ? 2'b01 : 2'b00);

  // ---- synchronizer, phase captures and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 6'h3F;
      r_sync2  <= 6'h3F;
      r_p0     <= 6'h3F;
      r_p1_sa  <= 2'b11;
      r_p1_lr  <= 2'b11;
      r_p5_dir <= 4'hF;
      r_p6_ext <= 4'hF;
      r_sel    <= 1'b1;
      r_joy    <= 6'h3F;
      r_ext    <= 6'h3F;
      r_type   <= 2'b00;
      r_done   <= 1'b0;
    end else begin
      r_sync1 <= db9_in;
      r_sync2 <= r_sync1;
      r_sel   <= w_sel_nxt;
      r_done  <= w_update;
      if (!enable) begin
        r_joy    <= r_sync2;
        r_ext    <= 6'h3F;
        r_type   <= 2'b00;
        r_p0     <= 6'h3F;
        r_p1_sa  <= 2'b11;
        r_p1_lr  <= 2'b11;
        r_p5_dir <= 4'hF;
        r_p6_ext <= 4'hF;
      end else begin
        if (w_step_end) begin
          case (r_state)
            c_st_p0: r_p0 <= r_sync2;
            c_st_p1: begin
              r_p1_sa <= r_sync2[5:4];
              r_p1_lr <= r_sync2[1:0];
            end
            c_st_p5: r_p5_dir <= r_sync2[3:0];
            c_st_p6: r_p6_ext <= r_sync2[3:0];
            default: ;
          endcase
        end
        if (w_update) begin
          r_joy  <= r_p0;
          r_ext  <= w_ext_nxt;
          r_type <= w_type_nxt;
        end
      end
    end
  end

  assign db9_sel    = r_sel;
  assign joy_out    = r_joy;
  assign ext_out    = r_ext;
  assign pad_type   = r_type;
  assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_db9_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_db9_pad_scanner
// Description : Scoreboard bench for db9_pad_scanner with Atari/MD3/MD6 pad
//               models, enable passthrough, reset and frame timing cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db9_pad_scanner;

  localparam int STEP  = 4;
  localparam int IDLE  = 2;
  localparam int FRAME = (8 + IDLE) * STEP;

  typedef struct packed {
    logic [5:0] joy;
    logic [5:0] ext;
    logic [1:0] pt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] db9_in;
  logic       db9_sel;
  logic [5:0] joy_out, ext_out;
  logic [1:0] pad_type;
  logic       frame_done;

  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [63:0] sel_log;

  // Pad model: mode 0 Atari, 1 MD3, 2 MD6, 3 unplugged.
  // btn = {mode,z,y,x,start,c,b,a,up,down,left,right}, active-low.
  int         pad_mode = 0;
  logic [5:0] atari_val = 6'h3F;
  logic [11:0] btn = 12'hFFF;
  int         lows = 0;
  int         hi_run = 0;
  logic       prev_sel = 1'b1;

  always #5 clk = ~clk;

  db9_pad_scanner #(
    .STEP_CYCLES(STEP),
    .IDLE_STEPS (IDLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .db9_in    (db9_in),
    .db9_sel   (db9_sel),
    .joy_out   (joy_out),
    .ext_out   (ext_out),
    .pad_type  (pad_type),
    .frame_done(frame_done)
  );

  // Low-phase counter of the pad; a long select-high run clears it.
  always @(negedge clk) begin
    hi_run <= db9_sel ? hi_run + 1 : 0;
    if (db9_sel && hi_run >= 6)   lows <= 0;
    else if (prev_sel && !db9_sel) lows <= lows + 1;
    prev_sel <= db9_sel;
  end

  always_comb begin
    db9_in = 6'h3F;
    case (pad_mode)
      0: db9_in = atari_val;
      1, 2: begin
        if (db9_sel) begin
          if (pad_mode == 2 && lows == 3) db9_in = {btn[6], btn[5], btn[10], btn[9], btn[8], btn[11]};
          else                            db9_in = {btn[6], btn[5], btn[3], btn[2], btn[1], btn[0]};
        end else begin
          if (pad_mode == 2 && lows == 3)      db9_in = {btn[7], btn[4], 4'b0000};
          else if (pad_mode == 2 && lows == 4) db9_in = {btn[7], btn[4], 4'b1111};
          else                                 db9_in = {btn[7], btn[4], btn[3], btn[2], 2'b00};
        end
      end
      default: db9_in = 6'h3F;
    endcase
  end

  function void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endfunction

  task automatic expect_frame(input logic [5:0] joy, input logic [5:0] ext, input logic [1:0] pt);
    exp_t e;
    e.joy = joy;
    e.ext = ext;
    e.pt  = pt;
    exp_q.push_back(e);
  endtask

  // Waits for the next frame_done, logging select per cycle along the way.
  task automatic wait_fd(input int bound, output int cycles);
    cycles  = 0;
    sel_log = '0;
    sel_log[0] = db9_sel;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles < 64) sel_log[cycles] = db9_sel;
    end while (!frame_done && cycles < bound);
    if (!frame_done) begin
      n_chk++;
      $display("FAIL frame_done timeout: no pulse within %0d cycles", bound);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected frame_done: got pulse, required none");
      end else begin
        mon_e = exp_q.pop_front();
        check("frame joy_out", 64'(joy_out), 64'(mon_e.joy));
        check("frame ext_out", 64'(ext_out), 64'(mon_e.ext));
        check("frame pad_type", 64'(pad_type), 64'(mon_e.pt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int fd_cnt;
    int low_cnt;
    logic [63:0] exp_sel;

    pad_mode  = 0;
    atari_val = 6'b101110;
    enable    = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset db9_sel", 64'(db9_sel), 64'd1);
    check("reset joy_out", 64'(joy_out), 64'h3F);
    check("reset ext_out", 64'(ext_out), 64'h3F);
    check("reset pad_type", 64'(pad_type), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);

    // Atari stick
    expect_frame(6'b101110, 6'h3F, 2'b00);
    rst_n = 1'b1;
    wait_fd(200, cyc);
    check("first update not before idle+scan", 64'(cyc >= FRAME), 64'd1);

    // MD3: Up, A, Start pressed
    pad_mode = 1;
    btn      = 12'hF67;
    expect_frame(6'b110111, 6'b111100, 2'b01);
    wait_fd(200, cyc);
    check("frame period", 64'(cyc), 64'(FRAME));
    exp_sel = '0;
    for (int i = 0; i < FRAME; i++)
      exp_sel[i] = (i < IDLE * STEP) ? 1'b1 : ((((i - IDLE * STEP) / STEP) % 2) == 0);
    check("select pattern over frame", sel_log & ((64'd1 << FRAME) - 1), exp_sel);

    // MD6: X and Mode pressed
    pad_mode = 2;
    btn      = 12'h6FF;
    expect_frame(6'h3F, 6'b011011, 2'b10);
    wait_fd(200, cyc);

    // Unplugged: pull-ups only
    pad_mode = 3;
    expect_frame(6'h3F, 6'h3F, 2'b00);
    wait_fd(200, cyc);

    // MD6: C and Start pressed
    pad_mode = 2;
    btn      = 12'hF3F;
    expect_frame(6'b011111, 6'b111101, 2'b10);
    wait_fd(200, cyc);

    // Disable in the middle of P3
    repeat (22) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable forces select high", 64'(db9_sel), 64'd1);
    pad_mode  = 0;
    atari_val = 6'b010101;
    repeat (3) @(negedge clk);
    check("passthrough joy_out", 64'(joy_out), 64'(6'b010101));
    check("passthrough ext_out", 64'(ext_out), 64'h3F);
    check("passthrough pad_type", 64'(pad_type), 64'd0);
    atari_val = 6'b111000;
    repeat (2) @(negedge clk);
    check("passthrough latency hold", 64'(joy_out), 64'(6'b010101));
    @(negedge clk);
    check("passthrough joy_out update", 64'(joy_out), 64'(6'b111000));
    fd_cnt  = 0;
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (!db9_sel)   low_cnt++;
    end
    check("disabled frame_done pulses", 64'(fd_cnt), 64'd0);
    check("disabled select low cycles", 64'(low_cnt), 64'd0);

    // Re-enable with MD6: Y, A, Right pressed
    pad_mode = 2;
    btn      = 12'hDEE;
    expect_frame(6'b111110, 6'b110110, 2'b10);
    enable = 1'b1;
    wait_fd(200, cyc);
    check("re-enable latency", 64'(cyc), 64'(FRAME));

    // Reset during P5 with MD6: X and Mode pressed
    btn = 12'h6FF;
    expect_frame(6'h3F, 6'b011011, 2'b10);
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset joy_out", 64'(joy_out), 64'h3F);
    check("async reset ext_out", 64'(ext_out), 64'h3F);
    check("async reset pad_type", 64'(pad_type), 64'd0);
    check("async reset db9_sel", 64'(db9_sel), 64'd1);
    check("async reset frame_done", 64'(frame_done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fd(200, cyc);
    check("post-reset update not before idle+scan", 64'(cyc >= FRAME), 64'd1);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
